// File: rtl/pipe_pkg.sv
// Shared EX/MEM pipeline definitions: datapath widths and the MEM/WB control bundle.
package pipe_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic branch;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = 5'b0_0000;

endpackage

// File: rtl/ex_mem_pipe_reg_if.sv
// EX/MEM boundary bundle: the EX side (master) drives the stage inputs, the register (slave) drives the MEM-side outputs.
interface ex_mem_pipe_reg_if #(
  parameter int DATA_WIDTH     = pipe_pkg::DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = pipe_pkg::REG_ADDR_WIDTH,
  parameter int CNT_WIDTH      = 16
);
  logic                      Stall;
  logic                      Flush;
  logic                      InValid;
  logic [DATA_WIDTH-1:0]     ALUResult;
  logic                      Zero;
  logic [DATA_WIDTH-1:0]     StoreData;
  logic [DATA_WIDTH-1:0]     BranchTarget;
  logic [REG_ADDR_WIDTH-1:0] WriteReg;
  logic                      RegWrite;
  logic                      MemRead;
  logic                      MemWrite;
  logic                      MemToReg;
  logic                      Branch;

  logic                      OutValid;
  logic [DATA_WIDTH-1:0]     OutALUResult;
  logic [DATA_WIDTH-1:0]     OutStoreData;
  logic [DATA_WIDTH-1:0]     OutBranchTarget;
  logic [REG_ADDR_WIDTH-1:0] OutWriteReg;
  logic                      OutRegWrite;
  logic                      OutMemRead;
  logic                      OutMemWrite;
  logic                      OutMemToReg;
  logic                      BranchTaken;
  logic                      FwdEn;
  logic [REG_ADDR_WIDTH-1:0] FwdReg;
  logic [DATA_WIDTH-1:0]     FwdData;
  logic [CNT_WIDTH-1:0]      StallCount;

  modport master (
    output Stall, Flush, InValid, ALUResult, Zero, StoreData, BranchTarget, WriteReg,
           RegWrite, MemRead, MemWrite, MemToReg, Branch,
    input  OutValid, OutALUResult, OutStoreData, OutBranchTarget, OutWriteReg,
           OutRegWrite, OutMemRead, OutMemWrite, OutMemToReg, BranchTaken,
           FwdEn, FwdReg, FwdData, StallCount
  );

  modport slave (
    input  Stall, Flush, InValid, ALUResult, Zero, StoreData, BranchTarget, WriteReg,
           RegWrite, MemRead, MemWrite, MemToReg, Branch,
    output OutValid, OutALUResult, OutStoreData, OutBranchTarget, OutWriteReg,
           OutRegWrite, OutMemRead, OutMemWrite, OutMemToReg, BranchTaken,
           FwdEn, FwdReg, FwdData, StallCount
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear; holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0] count_r;

  // Count enabled cycles, stopping at the maximum instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {WIDTH{1'b0}};
    end else if (en && (count_r != CNT_MAX)) begin
      count_r <= count_r + WIDTH'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register: captures ALU32Bit results and MEM/WB controls with flush > stall > load priority,
// resolves branch-taken, and feeds a registered forwarding source back to EX.
module ex_mem_pipe_reg #(
  parameter int DATA_WIDTH     = pipe_pkg::DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = pipe_pkg::REG_ADDR_WIDTH,
  parameter int CNT_WIDTH      = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  ex_mem_pipe_reg_if.slave bus
);
  import pipe_pkg::*;

  ctrl_t                     load_ctrl_s;
  ctrl_t                     ctrl_d_s;
  ctrl_t                     ctrl_r;
  logic                      valid_d_s;
  logic                      valid_r;
  logic [DATA_WIDTH-1:0]     alu_d_s;
  logic [DATA_WIDTH-1:0]     alu_r;
  logic [DATA_WIDTH-1:0]     store_d_s;
  logic [DATA_WIDTH-1:0]     store_r;
  logic [DATA_WIDTH-1:0]     target_d_s;
  logic [DATA_WIDTH-1:0]     target_r;
  logic [REG_ADDR_WIDTH-1:0] wreg_d_s;
  logic [REG_ADDR_WIDTH-1:0] wreg_r;
  logic                      stall_cnt_en_s;

  // Qualify EX controls with InValid; the branch field carries the resolved taken decision
  always_comb begin
    load_ctrl_s            = CTRL_BUBBLE;
    load_ctrl_s.reg_write  = bus.RegWrite & bus.InValid &
                             (bus.WriteReg != {REG_ADDR_WIDTH{1'b0}});
    load_ctrl_s.mem_read   = bus.MemRead   & bus.InValid;
    load_ctrl_s.mem_write  = bus.MemWrite  & bus.InValid;
    load_ctrl_s.mem_to_reg = bus.MemToReg  & bus.InValid;
    load_ctrl_s.branch     = bus.Branch & bus.Zero & bus.InValid;
  end

  // Select next stage contents: flush wins over stall, stall wins over load
  always_comb begin
    valid_d_s  = valid_r;
    ctrl_d_s   = ctrl_r;
    alu_d_s    = alu_r;
    store_d_s  = store_r;
    target_d_s = target_r;
    wreg_d_s   = wreg_r;
    if (bus.Flush) begin
      valid_d_s  = 1'b0;
      ctrl_d_s   = CTRL_BUBBLE;
      alu_d_s    = {DATA_WIDTH{1'b0}};
      store_d_s  = {DATA_WIDTH{1'b0}};
      target_d_s = {DATA_WIDTH{1'b0}};
      wreg_d_s   = {REG_ADDR_WIDTH{1'b0}};
    end else if (bus.Stall) begin
      valid_d_s  = valid_r;
      ctrl_d_s   = ctrl_r;
    end else begin
      valid_d_s  = bus.InValid;
      ctrl_d_s   = load_ctrl_s;
      alu_d_s    = bus.ALUResult;
      store_d_s  = bus.StoreData;
      target_d_s = bus.BranchTarget;
      wreg_d_s   = bus.WriteReg;
    end
  end

  // Stage register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      valid_r  <= 1'b0;
      ctrl_r   <= CTRL_BUBBLE;
      alu_r    <= {DATA_WIDTH{1'b0}};
      store_r  <= {DATA_WIDTH{1'b0}};
      target_r <= {DATA_WIDTH{1'b0}};
      wreg_r   <= {REG_ADDR_WIDTH{1'b0}};
    end else begin
      valid_r  <= valid_d_s;
      ctrl_r   <= ctrl_d_s;
      alu_r    <= alu_d_s;
      store_r  <= store_d_s;
      target_r <= target_d_s;
      wreg_r   <= wreg_d_s;
    end
  end

  assign bus.OutValid        = valid_r;
  assign bus.OutALUResult    = alu_r;
  assign bus.OutStoreData    = store_r;
  assign bus.OutBranchTarget = target_r;
  assign bus.OutWriteReg     = wreg_r;
  assign bus.OutRegWrite     = ctrl_r.reg_write;
  assign bus.OutMemRead      = ctrl_r.mem_read;
  assign bus.OutMemWrite     = ctrl_r.mem_write;
  assign bus.OutMemToReg     = ctrl_r.mem_to_reg;
  assign bus.BranchTaken     = ctrl_r.branch;

  // Loads are not forwardable from MEM; their data only exists after the memory access
  assign bus.FwdEn   = valid_r & ctrl_r.reg_write & ~ctrl_r.mem_to_reg;
  assign bus.FwdReg  = wreg_r;
  assign bus.FwdData = alu_r;

  assign stall_cnt_en_s = bus.Stall & ~bus.Flush;

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_stall_cnt (
    .clk   (Clk),
    .rst_n (Reset),
    .en    (stall_cnt_en_s),
    .count (bus.StallCount)
  );

endmodule

// File: doc/ex_mem_pipe_reg.md
Name: ex_mem_pipe_reg

Overview:
- EX/MEM pipeline register sitting directly downstream of ALU32Bit.
- Captures ALUResult/Zero plus store data, destination register and MEM/WB control from the EX stage each cycle.
- Supports stall (hold) and flush (bubble insertion), and resolves the branch-taken decision.
- Exposes a registered forwarding port back to the EX operand muxes and a saturating stall-cycle counter for debug.

Parameters:
DATA_WIDTH, 32, width of ALU result, store data and branch target
REG_ADDR_WIDTH, 5, register-file address width
CNT_WIDTH, 16, width of stall-cycle counter

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-low reset
Stall  in  1  hold all stage contents this cycle
Flush  in  1  load a bubble this cycle
InValid  in  1  EX stage holds a real instruction
ALUResult  in  DATA_WIDTH  result from ALU32Bit
Zero  in  1  ALU32Bit Zero flag
StoreData  in  DATA_WIDTH  rt value for sw
BranchTarget  in  DATA_WIDTH  computed branch target PC
WriteReg  in  REG_ADDR_WIDTH  destination register
RegWrite, MemRead, MemWrite, MemToReg, Branch  in  1 each  control bits from EX
OutValid  out  1  MEM stage holds a real instruction
OutALUResult, OutStoreData, OutBranchTarget  out  DATA_WIDTH  registered copies
OutWriteReg  out  REG_ADDR_WIDTH  registered destination
OutRegWrite, OutMemRead, OutMemWrite, OutMemToReg  out  1 each  registered, qualified controls
BranchTaken  out  1  registered Branch & Zero & InValid
FwdEn  out  1  forwarding source valid
FwdReg  out  REG_ADDR_WIDTH  forwarding destination
FwdData  out  DATA_WIDTH  forwarding value
StallCount  out  CNT_WIDTH  saturating count of stalled cycles

Behaviour:
- Reset low, asynchronous: every output and internal register goes to 0 immediately, including StallCount. Release is synchronous to the next Clk edge.
- Priority per rising edge: Flush > Stall > Load.
- Flush: OutValid, all Out* control bits and BranchTaken go to 0. Data fields (OutALUResult, OutStoreData, OutBranchTarget, OutWriteReg) go to 0.
- Stall (without Flush): every register holds its value. StallCount increments by 1 and saturates at all-ones (no wrap).
- Load: latency 1 cycle; all inputs are captured.
  - OutValid <= InValid.
  - Each Out* control bit <= input & InValid, so invalid slots never write memory or the register file.
  - OutRegWrite is additionally forced to 0 when WriteReg == 0 ($zero is never written).
  - BranchTaken <= Branch & Zero & InValid.
- Simultaneous Flush and Stall: a bubble is loaded and StallCount does not increment.
- MemRead and MemWrite both set on an input: both are passed through; no arbitration is done here.
- Forwarding is combinational from registered state only, with no input-to-output path:
  - FwdEn = OutValid & OutRegWrite & ~OutMemToReg. Loads are not forwardable from MEM; the hazard unit stalls instead.
  - FwdReg = OutWriteReg.
  - FwdData = OutALUResult.
  - When FwdEn = 0, FwdReg/FwdData still show the register contents and consumers must ignore them.
- No state machine beyond the valid bit. StallCount is the only free-running state.
- Reset asserted mid-stall clears contents; the first post-reset edge with Stall = 0 loads normally.

Decomposition:
- Shared package pipe_pkg holds:
  - DATA_WIDTH and REG_ADDR_WIDTH constants.
  - A ctrl bundle typedef {RegWrite, MemRead, MemWrite, MemToReg, Branch}.
  - A CTRL_BUBBLE constant (all zeros).
- One sub-module is natural: sat_counter (parameterised width, enable, async active-low clear). It is reused later for other stall/flush statistics.
- Register fields stay in the top module.

Test Plan:
- Reset low mid-run, with the register previously loaded with ALUResult = 742 -> all outputs 0 immediately, before any Clk edge; StallCount = 0.
- Load ALUResult = 742, WriteReg = 8, RegWrite = 1, InValid = 1 -> after one edge: OutALUResult = 742, OutRegWrite = 1, FwdEn = 1, FwdReg = 8, FwdData = 742.
- Load with WriteReg = 0, RegWrite = 1 -> OutRegWrite = 0, FwdEn = 0. Load with MemToReg = 1 -> FwdEn = 0, OutMemToReg = 1.
- Stall = 1 for 3 edges while inputs change to ALUResult = 690 -> outputs hold 742; StallCount = 3. With CNT_WIDTH = 4 and 20 stall edges -> StallCount = 15.
- Flush = 1 and Stall = 1 together, with MemWrite = 1 and InValid = 1 -> OutValid = 0, OutMemWrite = 0, OutALUResult = 0; StallCount unchanged.
- Branch = 1, Zero = 1, InValid = 1, BranchTarget = 0x40 -> BranchTaken = 1, OutBranchTarget = 0x40. Same stimulus with InValid = 0 -> BranchTaken = 0.
